fpna_cfg_loader: RTL and testbench
==================================

Name: fpna_cfg_loader

Overview:
- Configuration sequencer for the neurochip's field-programmable neural array.
- Accepts configuration bytes over a valid/ready byte interface and serializes them MSB-first onto the array's scan chain (bs_in / config_en).
- Holds the array in reset (reset_nn) while loading.
- Captures the bits falling out of the chain tail (bs_out) as readback bytes, so previous contents can be verified.

Parameters:
- CHAIN_LEN, 64, number of configuration bits in the array scan chain (>=1, <=65535).
- CLR_CYCLES, 4, cycles array_rst_n is held low in CLEAR before shifting starts (>=1, <=255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- start  input  1  begin a load; sampled only in IDLE.
- abort  input  1  cancel an in-progress load.
- cfg_byte  input  8  configuration byte, bit 7 shifted first.
- cfg_valid  input  1  cfg_byte valid.
- cfg_ready  output  1  loader can accept cfg_byte this cycle.
- chain_bit  output  1  serial data to chain head (bs_in).
- chain_en  output  1  chain shift enable (config_en); one bit moves per cycle while high.
- chain_tail  input  1  serial data from chain tail (bs_out).
- rb_byte  output  8  readback byte.
- rb_valid  output  1  one-cycle pulse, rb_byte valid.
- array_rst_n  output  1  active-low reset to array (reset_nn).
- busy  output  1  high in any state other than IDLE.
- configured  output  1  high after a completed load, until next start/abort/reset.
- done  output  1  one-cycle pulse on load completion.
- err  output  1  one-cycle pulse when abort cancels a load.

Behaviour:
- Reset values:
  - all outputs 0, including array_rst_n (array unconfigured stays in reset).
  - state = IDLE; all counters 0.
- States: IDLE, CLEAR, LOAD, FINISH.
- IDLE -> CLEAR:
  - on start=1; next cycle busy=1, configured=0, array_rst_n=0.
  - start while busy is ignored.
- CLEAR:
  - counts CLR_CYCLES cycles, then enters LOAD.
  - bit counter = CHAIN_LEN; byte shift register empty.
- LOAD:
  - cfg_ready=1 iff the byte shift register is empty and remaining bits > 0.
  - A byte is accepted on cfg_valid & cfg_ready; it loads the shift register, so cfg_ready drops the next cycle.
  - Each following cycle: chain_en=1, chain_bit = sr[7], sr shifts left, remaining decrements.
  - Each byte shifts min(8, remaining) bits. For a partial last byte only its upper bits are used; the low bits are discarded.
  - Throughput: 8 shift cycles plus 1 accept cycle per byte. Stalled cfg_valid leaves chain_en=0 with no shifting.
  - Readback: on every chain_en cycle chain_tail is shifted into rb_sr (captured first = MSB).
  - After 8 captured bits, or after the final bit of a partial group, rb_byte is emitted with the group left-aligned and zero-padded low, and rb_valid pulses the following cycle.
  - remaining reaching 0 -> FINISH.
- FINISH: one cycle. done=1, configured=1, array_rst_n=1 from the next cycle; then IDLE, busy=0.
- abort:
  - In CLEAR or LOAD: next cycle state=IDLE, err=1 (one cycle), busy=0, array_rst_n=0, configured=0.
  - Partial readback is discarded (no rb_valid).
  - abort in IDLE or FINISH is ignored. abort has priority over a same-cycle byte accept.
- chain_en never high outside LOAD.
- Total ones on chain_en per completed load = CHAIN_LEN exactly.
- rst_n low at any time: immediate return to reset values; a mid-load state is lost.

Test Plan:
- CHAIN_LEN=16, bytes 0xA5,0x3C sent back-to-back:
  - chain_bit sequence 1010010100111100 on 16 chain_en cycles.
  - done pulse once, configured=1, array_rst_n=1 afterwards.
- Chain model preloaded 0xFF00, load 0x0000:
  - rb_valid pulses twice with rb_byte 0xFF then 0x00.
  - Model contents afterwards = 0x0000.
- CHAIN_LEN=12, bytes 0xF0,0xAB:
  - 12 shift cycles, bits 111100001010.
  - Second readback byte left-aligned with low 4 bits 0.
- Throttled source (cfg_valid low 5 cycles between bytes):
  - chain_en low during gaps; shifted data identical to the back-to-back case.
- abort asserted after 5 shifted bits:
  - next cycle err=1, busy=0, configured=0, array_rst_n=0.
  - no done, no further chain_en.
  - a new start then completes normally.
- rst_n pulsed low mid-LOAD, plus start asserted while busy:
  - all outputs 0 immediately on reset.
  - start while busy has no effect on the bit count.

Source files
------------

// File: rtl/fpna_cfg_loader_if.sv
// Byte stream into the loader (cfg_*) and readback byte stream out of it (rb_*).
interface fpna_cfg_loader_if;
   logic [7:0] cfg_byte;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] rb_byte;
   logic       rb_valid;

   modport master (
      output cfg_byte,
      output cfg_valid,
      input  cfg_ready,
      input  rb_byte,
      input  rb_valid
   );

   modport slave (
      input  cfg_byte,
      input  cfg_valid,
      output cfg_ready,
      output rb_byte,
      output rb_valid
   );
endinterface

// File: rtl/fpna_cfg_loader.sv
// Configuration sequencer for the field-programmable neural array.
// Serializes accepted bytes MSB-first into the array scan chain while the
// array is held in reset, and returns the bits falling out of the chain tail
// as left-aligned readback bytes.
module fpna_cfg_loader #(
   parameter int CHAIN_LEN  = 64,
   parameter int CLR_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   fpna_cfg_loader_if.slave cfg,
   output logic             chain_bit,
   output logic             chain_en,
   input  logic             chain_tail,
   output logic             array_rst_n,
   output logic             busy,
   output logic             configured,
   output logic             done,
   output logic             err
);

   localparam logic [7:0]  CLR_LAST   = 8'(CLR_CYCLES - 1);
   localparam logic [15:0] CHAIN_BITS = 16'(CHAIN_LEN);

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, FINISH} state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  clr_cnt;
   logic [15:0] remaining;   // chain bits still to be shifted
   logic [7:0]  sr;          // outgoing byte, sr[7] is the next chain bit
   logic [3:0]  sr_cnt;      // bits of sr still to shift; 0 means empty
   logic [7:0]  rb_sr;       // readback group being assembled
   logic [3:0]  rb_cnt;      // bits captured in the current readback group
   logic        ready;
   logic        accept;
   logic        shift;
   logic        abort_hit;
   logic        last_bit;
   logic [7:0]  rb_shifted;
   logic [3:0]  rb_cnt_inc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and handshake decode; abort wins over any same-cycle accept or shift
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      accept     = 1'b0;
      shift      = 1'b0;
      abort_hit  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = CLEAR;
         end
         CLEAR: begin
            if (abort) begin
               abort_hit  = 1'b1;
               state_next = IDLE;
            end else if (clr_cnt == CLR_LAST) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            ready = (sr_cnt == 4'd0) && (remaining != 16'd0);
            if (abort) begin
               abort_hit  = 1'b1;
               state_next = IDLE;
            end else begin
               accept = ready && cfg.cfg_valid;
               shift  = (sr_cnt != 4'd0);
               if (shift && (remaining == 16'd1)) state_next = FINISH;
            end
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign cfg.cfg_ready = ready;
   assign chain_en      = shift;
   assign chain_bit     = shift & sr[7];
   assign busy          = (state != IDLE);
   assign last_bit      = (remaining == 16'd1);
   assign rb_shifted    = {rb_sr[6:0], chain_tail};
   assign rb_cnt_inc    = rb_cnt + 4'd1;

   // Counters, shift registers and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt      <= '0;
         remaining    <= '0;
         sr           <= '0;
         sr_cnt       <= '0;
         rb_sr        <= '0;
         rb_cnt       <= '0;
         cfg.rb_byte  <= '0;
         cfg.rb_valid <= 1'b0;
         array_rst_n  <= 1'b0;
         configured   <= 1'b0;
         err          <= 1'b0;
      end else begin
         cfg.rb_valid <= 1'b0;
         err          <= abort_hit;
         case (state)
            IDLE: begin
               clr_cnt <= '0;
               if (start) begin
                  configured  <= 1'b0;
                  array_rst_n <= 1'b0;
               end
            end
            CLEAR: begin
               clr_cnt   <= clr_cnt + 8'd1;
               remaining <= CHAIN_BITS;
               sr        <= '0;
               sr_cnt    <= '0;
               rb_sr     <= '0;
               rb_cnt    <= '0;
            end
            LOAD: begin
               if (accept) begin
                  // a short final byte only contributes its upper bits
                  sr     <= cfg.cfg_byte;
                  sr_cnt <= (remaining >= 16'd8) ? 4'd8 : remaining[3:0];
               end
               if (shift) begin
                  sr        <= {sr[6:0], 1'b0};
                  sr_cnt    <= sr_cnt - 4'd1;
                  remaining <= remaining - 16'd1;
                  if ((rb_cnt_inc == 4'd8) || last_bit) begin
                     cfg.rb_byte  <= rb_shifted << (4'd8 - rb_cnt_inc);
                     cfg.rb_valid <= 1'b1;
                     rb_sr        <= '0;
                     rb_cnt       <= '0;
                  end else begin
                     rb_sr  <= rb_shifted;
                     rb_cnt <= rb_cnt_inc;
                  end
               end
            end
            FINISH: begin
               configured  <= 1'b1;
               array_rst_n <= 1'b1;
            end
            default: ;
         endcase
         if (abort_hit) begin
            // partial readback is dropped, array stays in reset
            sr_cnt      <= '0;
            rb_sr       <= '0;
            rb_cnt      <= '0;
            configured  <= 1'b0;
            array_rst_n <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fpna_cfg_loader.sv
// Bench for fpna_cfg_loader: a 16-bit and a 12-bit loader share stimulus,
// each feeding a behavioural scan-chain model; results are compared against
// expectations derived from the byte list and the chain's prior contents.
module tb_fpna_cfg_loader;

   localparam int CLR = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, abort, cfg_valid, sel;
   logic [7:0] cfg_byte;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always @(posedge clk) cyc++;

   fpna_cfg_loader_if if_a ();
   fpna_cfg_loader_if if_b ();

   logic start_a, start_b, abort_a, abort_b;
   logic cb_a, ce_a, ar_a, bz_a, cf_a, dn_a, er_a, tail_a;
   logic cb_b, ce_b, ar_b, bz_b, cf_b, dn_b, er_b, tail_b;

   assign start_a = start & ~sel;
   assign start_b = start & sel;
   assign abort_a = abort & ~sel;
   assign abort_b = abort & sel;
   assign if_a.cfg_byte  = cfg_byte;
   assign if_b.cfg_byte  = cfg_byte;
   assign if_a.cfg_valid = cfg_valid & ~sel;
   assign if_b.cfg_valid = cfg_valid & sel;

   fpna_cfg_loader #(.CHAIN_LEN(16), .CLR_CYCLES(CLR)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .cfg(if_a),
      .chain_bit(cb_a), .chain_en(ce_a), .chain_tail(tail_a),
      .array_rst_n(ar_a), .busy(bz_a), .configured(cf_a), .done(dn_a), .err(er_a));

   fpna_cfg_loader #(.CHAIN_LEN(12), .CLR_CYCLES(CLR)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .cfg(if_b),
      .chain_bit(cb_b), .chain_en(ce_b), .chain_tail(tail_b),
      .array_rst_n(ar_b), .busy(bz_b), .configured(cf_b), .done(dn_b), .err(er_b));

   // observed signals of the selected loader
   logic       o_en, o_bit, o_ready, o_rbv, o_done, o_err, o_busy, o_conf, o_arn;
   logic [7:0] o_rb;
   logic [16:0] va, vb, o_vec;
   assign o_en    = sel ? ce_b : ce_a;
   assign o_bit   = sel ? cb_b : cb_a;
   assign o_ready = sel ? if_b.cfg_ready : if_a.cfg_ready;
   assign o_rbv   = sel ? if_b.rb_valid : if_a.rb_valid;
   assign o_rb    = sel ? if_b.rb_byte : if_a.rb_byte;
   assign o_done  = sel ? dn_b : dn_a;
   assign o_err   = sel ? er_b : er_a;
   assign o_busy  = sel ? bz_b : bz_a;
   assign o_conf  = sel ? cf_b : cf_a;
   assign o_arn   = sel ? ar_b : ar_a;
   assign va = {ar_a, bz_a, cf_a, dn_a, er_a, ce_a, cb_a, if_a.cfg_ready, if_a.rb_valid, if_a.rb_byte};
   assign vb = {ar_b, bz_b, cf_b, dn_b, er_b, ce_b, cb_b, if_b.cfg_ready, if_b.rb_valid, if_b.rb_byte};
   assign o_vec = sel ? vb : va;

   // behavioural scan chains: tail is the oldest bit
   logic [15:0] ch_a = '0;
   logic [11:0] ch_b = '0;
   logic        pre_req = 1'b0;
   logic [15:0] pre_val = '0;
   always @(posedge clk) begin
      if (pre_req) begin
         if (sel) ch_b <= pre_val[11:0];
         else     ch_a <= pre_val;
      end else begin
         if (ce_a) ch_a <= {ch_a[14:0], cb_a};
         if (ce_b) ch_b <= {ch_b[10:0], cb_b};
      end
   end
   assign tail_a = ch_a[15];
   assign tail_b = ch_b[11];

   // monitor, sampled on the falling edge
   bit         mon_bits[$];
   logic [7:0] mon_rb[$];
   int         n_done = 0;
   int         n_err = 0;
   always @(negedge clk) begin
      if (o_en)   mon_bits.push_back(o_bit);
      if (o_rbv)  mon_rb.push_back(o_rb);
      if (o_done) n_done++;
      if (o_err)  n_err++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model state
   logic [7:0]  load_q[$];
   logic [15:0] exp_chain, exp_rb_vec;
   int          exp_rb_n, exp_lat;
   int          b_bits, b_rb, b_done, b_err;
   int          lat;
   bit          tmo;

   function automatic int chain_len();
      return sel ? 12 : 16;
   endfunction

   function automatic logic [15:0] cur_chain();
      return sel ? {4'b0, ch_b} : ch_a;
   endfunction

   // expected shifted bits, readback bytes, final chain and latency
   function automatic void build_model(input logic [15:0] prior, input int gap);
      int         len = chain_len();
      int         rem = len;
      int         n = 0;
      int         nb;
      logic [7:0] b;
      logic [7:0] acc = '0;
      exp_chain  = '0;
      exp_rb_vec = '0;
      exp_rb_n   = 0;
      for (int i = 0; i < len; i++) begin
         b = load_q[i / 8];
         exp_chain = {exp_chain[14:0], b[7 - (i % 8)]};
         acc[7 - n] = prior[len - 1 - i];
         n++;
         if (n == 8 || i == len - 1) begin
            exp_rb_vec = {exp_rb_vec[7:0], acc};
            exp_rb_n++;
            acc = '0;
            n = 0;
         end
      end
      exp_lat = CLR + 1;
      for (int k = 0; k < load_q.size() && rem > 0; k++) begin
         nb = (rem > 8) ? 8 : rem;
         exp_lat += 1 + nb + ((k > 0) ? gap : 0);
         rem -= nb;
      end
   endfunction

   function automatic logic [15:0] pack_bits();
      logic [15:0] v = '0;
      for (int i = b_bits; i < mon_bits.size(); i++) v = {v[14:0], mon_bits[i]};
      return v;
   endfunction

   function automatic logic [15:0] pack_rb();
      logic [15:0] v = '0;
      for (int i = b_rb; i < mon_rb.size(); i++) v = {v[7:0], mon_rb[i]};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mark();
      b_bits = mon_bits.size();
      b_rb   = mon_rb.size();
      b_done = n_done;
      b_err  = n_err;
   endtask

   task automatic preload(input logic [15:0] v);
      pre_val = v;
      pre_req = 1'b1;
      tick();
      pre_req = 1'b0;
   endtask

   // drive one full load of load_q; noise raises start while the loader is busy
   task automatic do_load(input int gap, input bit noise, output int l, output bit t);
      int t0;
      int n;
      t = 1'b0;
      l = 0;
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
      for (int k = 0; k < load_q.size(); k++) begin
         n = 0;
         while (!o_ready && n < 100) begin
            start = noise;
            tick();
            n++;
         end
         if (!o_ready) begin
            start = 1'b0;
            t = 1'b1;
            return;
         end
         if (k > 0) begin
            repeat (gap) begin
               start = noise;
               tick();
            end
         end
         start = 1'b0;
         cfg_byte = load_q[k];
         cfg_valid = 1'b1;
         tick();
         cfg_valid = 1'b0;
      end
      n = 0;
      while (!o_done && n < 100) begin
         tick();
         n++;
      end
      if (o_done) l = cyc - t0;
      else        t = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      checks++;
      if (va !== 17'd0) begin errors++; $display("FAIL reset_a16: got %h expected %h", va, 17'd0); end
      checks++;
      if (vb !== 17'd0) begin errors++; $display("FAIL reset_b12: got %h expected %h", vb, 17'd0); end
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if ({va, vb} !== 34'd0) begin errors++; $display("FAIL reset_release: got %h expected %h", {va, vb}, 34'd0); end
      $display("test_reset: outputs after reset a=%h b=%h", va, vb);
   endtask

   task automatic test_back_to_back();
      logic [15:0] prior, got;
      sel = 1'b0;
      preload(16'($urandom));
      prior = cur_chain();
      load_q = '{8'hA5, 8'h3C};
      build_model(prior, 0);
      mark();
      do_load(0, 1'b0, lat, tmo);
      got = pack_bits();
      checks++;
      if (tmo) begin errors++; $display("FAIL b2b_timeout: got %0d expected %0d", tmo, 0); end
      checks++;
      if (mon_bits.size() - b_bits != 16 || got !== 16'b1010010100111100)
         begin errors++; $display("FAIL b2b_bits: got %0d bits %h expected 16 bits %h", mon_bits.size() - b_bits, got, 16'hA53C); end
      checks++;
      if (n_done - b_done != 1) begin errors++; $display("FAIL b2b_done: got %0d expected %0d", n_done - b_done, 1); end
      checks++;
      if ({o_conf, o_arn, o_busy} !== 3'b110) begin errors++; $display("FAIL b2b_status: got %b expected %b", {o_conf, o_arn, o_busy}, 3'b110); end
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, exp_lat); end
      checks++;
      if (mon_rb.size() - b_rb != exp_rb_n || pack_rb() !== exp_rb_vec)
         begin errors++; $display("FAIL b2b_readback: got %0d bytes %h expected %0d bytes %h", mon_rb.size() - b_rb, pack_rb(), exp_rb_n, exp_rb_vec); end
      checks++;
      if (cur_chain() !== 16'hA53C) begin errors++; $display("FAIL b2b_chain: got %h expected %h", cur_chain(), 16'hA53C); end
      $display("test_back_to_back: bits=%h latency=%0d readback=%h", got, lat, pack_rb());
   endtask

   task automatic test_readback();
      sel = 1'b0;
      preload(16'hFF00);
      load_q = '{8'h00, 8'h00};
      mark();
      do_load(0, 1'b0, lat, tmo);
      checks++;
      if (mon_rb.size() - b_rb != 2 || pack_rb() !== 16'hFF00)
         begin errors++; $display("FAIL rb_bytes: got %0d bytes %h expected 2 bytes %h", mon_rb.size() - b_rb, pack_rb(), 16'hFF00); end
      checks++;
      if (cur_chain() !== 16'h0000) begin errors++; $display("FAIL rb_chain: got %h expected %h", cur_chain(), 16'h0000); end
      checks++;
      if (n_done - b_done != 1 || tmo) begin errors++; $display("FAIL rb_done: got %0d expected %0d", n_done - b_done, 1); end
      $display("test_readback: readback=%h chain=%h", pack_rb(), cur_chain());
   endtask

   task automatic test_partial();
      logic [15:0] prior, got, rb;
      sel = 1'b1;
      preload(16'($urandom));
      prior = cur_chain();
      load_q = '{8'hF0, 8'hAB};
      build_model(prior, 0);
      mark();
      do_load(0, 1'b0, lat, tmo);
      got = pack_bits();
      rb = pack_rb();
      checks++;
      if (mon_bits.size() - b_bits != 12 || got !== 16'h0F0A)
         begin errors++; $display("FAIL part_bits: got %0d bits %h expected 12 bits %h", mon_bits.size() - b_bits, got, 16'h0F0A); end
      checks++;
      if (mon_rb.size() - b_rb != exp_rb_n || rb !== exp_rb_vec)
         begin errors++; $display("FAIL part_readback: got %0d bytes %h expected %0d bytes %h", mon_rb.size() - b_rb, rb, exp_rb_n, exp_rb_vec); end
      checks++;
      if (rb[3:0] !== 4'h0) begin errors++; $display("FAIL part_pad: got %h expected %h", rb[3:0], 4'h0); end
      checks++;
      if (lat != exp_lat || tmo) begin errors++; $display("FAIL part_latency: got %0d expected %0d", lat, exp_lat); end
      checks++;
      if (cur_chain() !== 16'h0F0A) begin errors++; $display("FAIL part_chain: got %h expected %h", cur_chain(), 16'h0F0A); end
      $display("test_partial: bits=%h readback=%h latency=%0d", got, rb, lat);
   endtask

   task automatic test_throttled();
      logic [15:0] prior, got;
      sel = 1'b0;
      preload(16'($urandom));
      prior = cur_chain();
      load_q = '{8'($urandom), 8'($urandom)};
      build_model(prior, 5);
      mark();
      do_load(5, 1'b0, lat, tmo);
      got = pack_bits();
      checks++;
      if (mon_bits.size() - b_bits != 16 || got !== exp_chain)
         begin errors++; $display("FAIL thr_bits: got %0d bits %h expected 16 bits %h", mon_bits.size() - b_bits, got, exp_chain); end
      checks++;
      if (lat != exp_lat || tmo) begin errors++; $display("FAIL thr_latency: got %0d expected %0d", lat, exp_lat); end
      checks++;
      if (pack_rb() !== exp_rb_vec) begin errors++; $display("FAIL thr_readback: got %h expected %h", pack_rb(), exp_rb_vec); end
      $display("test_throttled: bytes=%h%h bits=%h latency=%0d", load_q[0], load_q[1], got, lat);
   endtask

   task automatic test_abort();
      logic [7:0]  b;
      logic [15:0] got, prior;
      int          n;
      sel = 1'b0;
      preload(16'($urandom));
      mark();
      b = 8'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!o_ready && n < 50) begin tick(); n++; end
      cfg_byte = b;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      repeat (5) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      got = pack_bits();
      checks++;
      if ({o_err, o_busy, o_conf, o_arn} !== 4'b1000)
         begin errors++; $display("FAIL abort_status: got %b expected %b", {o_err, o_busy, o_conf, o_arn}, 4'b1000); end
      checks++;
      if (mon_bits.size() - b_bits != 5 || got[4:0] !== b[7:3])
         begin errors++; $display("FAIL abort_bits: got %0d bits %h expected 5 bits %h", mon_bits.size() - b_bits, got[4:0], b[7:3]); end
      repeat (20) tick();
      checks++;
      if (n_err - b_err != 1 || n_done != b_done || mon_bits.size() - b_bits != 5 || mon_rb.size() != b_rb)
         begin errors++; $display("FAIL abort_after: got err=%0d done=%0d bits=%0d rb=%0d expected 1 0 5 0",
                                  n_err - b_err, n_done - b_done, mon_bits.size() - b_bits, mon_rb.size() - b_rb); end
      prior = cur_chain();
      load_q = '{8'($urandom), 8'($urandom)};
      build_model(prior, 0);
      mark();
      do_load(0, 1'b0, lat, tmo);
      got = pack_bits();
      checks++;
      if (tmo || n_done - b_done != 1 || got !== exp_chain || o_conf !== 1'b1)
         begin errors++; $display("FAIL abort_reload: got done=%0d bits=%h conf=%b expected 1 %h 1", n_done - b_done, got, o_conf, exp_chain); end
      checks++;
      if (pack_rb() !== exp_rb_vec) begin errors++; $display("FAIL abort_reload_rb: got %h expected %h", pack_rb(), exp_rb_vec); end
      $display("test_abort: byte=%h shifted=%0d reload bits=%h", b, 5, got);
   endtask

   task automatic test_reset_mid();
      logic [15:0] prior, got;
      int          n;
      sel = 1'b0;
      preload(16'($urandom));
      prior = cur_chain();
      load_q = '{8'($urandom), 8'($urandom)};
      build_model(prior, 3);
      mark();
      do_load(3, 1'b1, lat, tmo);
      got = pack_bits();
      checks++;
      if (mon_bits.size() - b_bits != 16 || got !== exp_chain || lat != exp_lat || tmo)
         begin errors++; $display("FAIL busy_start: got %0d bits %h lat %0d expected 16 bits %h lat %0d",
                                  mon_bits.size() - b_bits, got, lat, exp_chain, exp_lat); end
      mark();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!o_ready && n < 50) begin tick(); n++; end
      cfg_byte = 8'($urandom);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_vec !== 17'd0) begin errors++; $display("FAIL midreset_outputs: got %h expected %h", o_vec, 17'd0); end
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      checks++;
      if (o_vec !== 17'd0 || n_done != b_done)
         begin errors++; $display("FAIL midreset_idle: got %h done=%0d expected %h done=0", o_vec, n_done - b_done, 17'd0); end
      $display("test_reset_mid: busy-start bits=%h latency=%0d, post-reset outputs=%h", got, lat, o_vec);
   endtask

   task automatic test_random();
      logic [15:0] prior, got;
      int          gap;
      for (int it = 0; it < 8; it++) begin
         sel = 1'($urandom_range(0, 1));
         preload(16'($urandom));
         prior = cur_chain();
         load_q = '{8'($urandom), 8'($urandom)};
         gap = $urandom_range(0, 3);
         build_model(prior, gap);
         mark();
         do_load(gap, 1'b0, lat, tmo);
         got = pack_bits();
         checks++;
         if (mon_bits.size() - b_bits != chain_len() || got !== exp_chain)
            begin errors++; $display("FAIL rand_bits[%0d]: got %0d bits %h expected %0d bits %h", it, mon_bits.size() - b_bits, got, chain_len(), exp_chain); end
         checks++;
         if (pack_rb() !== exp_rb_vec || mon_rb.size() - b_rb != exp_rb_n)
            begin errors++; $display("FAIL rand_rb[%0d]: got %h expected %h", it, pack_rb(), exp_rb_vec); end
         checks++;
         if (cur_chain() !== exp_chain) begin errors++; $display("FAIL rand_chain[%0d]: got %h expected %h", it, cur_chain(), exp_chain); end
         checks++;
         if (tmo || lat != exp_lat || n_done - b_done != 1 || o_conf !== 1'b1 || o_arn !== 1'b1)
            begin errors++; $display("FAIL rand_done[%0d]: got lat %0d done %0d conf %b arn %b expected lat %0d done 1 conf 1 arn 1",
                                     it, lat, n_done - b_done, o_conf, o_arn, exp_lat); end
         $display("test_random[%0d]: len=%0d gap=%0d bytes=%h%h bits=%h readback=%h", it, chain_len(), gap, load_q[0], load_q[1], got, pack_rb());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      cfg_valid = 1'b0;
      cfg_byte = '0;
      sel = 1'b0;
      test_reset();
      test_back_to_back();
      test_readback();
      test_partial();
      test_throttled();
      test_abort();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
